// File: rtl/timer_tick_gen.sv
// -----------------------------------------------------------------------------
// timer_tick_gen
//
// Count-enable generator for the 8-bit timer counter. Divides pclk by
// N = 2^(cks+1) (2, 4, 8 or 16) and emits a registered one-cycle `tick`.
// The divider phase is held while `en` is low, so a stop/restart never loses
// a partial period. A ratio change made while running takes effect only on
// the wrap cycle, so the period in progress always completes at the old ratio.
//
// Optional feature: define TIMER_EXT_CLK_EN to add an external clock source
// (ext_clk through a 2-flop synchronizer plus a rising-edge detect flop).
//
// Parameters:
//   DIV_W    divider counter width, must be >= 4 so the /16 ratio fits
//
// Ports:
//   pclk     in   system clock, rising edge
//   preset   in   synchronous active-high reset
//   en       in   TCR.en, divider runs while high
//   cks      in   TCR.cks, ratio select
//   div_clr  in   single-cycle pulse, clears the divider phase
//   ext_clk  in   asynchronous external clock     (TIMER_EXT_CLK_EN only)
//   ext_sel  in   selects the external source     (TIMER_EXT_CLK_EN only)
//   tick     out  registered one-pclk count-enable pulse
//   cks_act  out  ratio select currently applied
//   running  out  registered copy of en
// -----------------------------------------------------------------------------
module timer_tick_gen #(
  parameter int DIV_W = 4
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       en,
  input  logic [1:0] cks,
  input  logic       div_clr,
`ifdef TIMER_EXT_CLK_EN
  input  logic       ext_clk,
  input  logic       ext_sel,
`endif
  output logic       tick,
  output logic [1:0] cks_act,
  output logic       running
);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic             tick_reg;
  logic [1:0]       cks_act_reg;

  logic [DIV_W-1:0] term_val;
  logic             terminal;
  logic             use_ext;
  logic             ext_pulse;

  // Terminal count is N_act-1 for the ratio currently applied.
  always_comb begin
    term_val = DIV_W'(1);
    case (cks_act_reg)
      2'd0:    term_val = DIV_W'(1);
      2'd1:    term_val = DIV_W'(3);
      2'd2:    term_val = DIV_W'(7);
      default: term_val = DIV_W'(15);
    endcase
  end

  // >= rather than ==: a ratio shrunk while stopped may leave the held
  // count above the new terminal; the next enabled cycle then wraps at once.
  assign terminal = (cnt_reg >= term_val);

`ifdef TIMER_EXT_CLK_EN
  // sync_reg[0..1] form the synchronizer, sync_reg[2] is the edge-detect
  // flop. div_clr clears only the edge-detect flop.
  logic [2:0] sync_reg;

  always_ff @(posedge pclk) begin
    if (preset) begin
      sync_reg <= 3'b000;
    end else begin
      sync_reg[0] <= ext_clk;
      sync_reg[1] <= sync_reg[0];
      sync_reg[2] <= div_clr ? 1'b0 : sync_reg[1];
    end
  end

  assign ext_pulse = sync_reg[1] & ~sync_reg[2];
  assign use_ext   = ext_sel;
`else
  assign ext_pulse = 1'b0;
  assign use_ext   = 1'b0;
`endif

  // STOP/RUN follow en directly; all outputs are registered here.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg   <= ST_STOP;
      cnt_reg     <= '0;
      tick_reg    <= 1'b0;
      cks_act_reg <= 2'b00;
    end else begin
      state_reg <= en ? ST_RUN : ST_STOP;
      if (div_clr) begin
        cnt_reg     <= '0;
        tick_reg    <= 1'b0;
        cks_act_reg <= cks;
      end else if (!en) begin
        // Phase held; ratio tracks cks freely while stopped.
        tick_reg    <= 1'b0;
        cks_act_reg <= cks;
      end else if (use_ext) begin
        // External source: divider phase frozen, tick follows the edge.
        tick_reg <= ext_pulse;
      end else if (terminal) begin
        cnt_reg     <= '0;
        tick_reg    <= 1'b1;
        cks_act_reg <= cks;
      end else begin
        cnt_reg  <= cnt_reg + DIV_W'(1);
        tick_reg <= 1'b0;
      end
    end
  end

  assign tick    = tick_reg;
  assign cks_act = cks_act_reg;
  assign running = (state_reg == ST_RUN);

endmodule
